// File: rtl/led_mode_sequencer_pkg.sv
// Shared types and constants for the LED mode sequencer: mode encoding,
// the colour-cycle table and the brightness step/reset values.
package led_mode_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_MANUAL  = 2'd1,
        MODE_CYCLE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    localparam int NUM_COLORS = 6;

    // {R,G,B}; entry 0 is the rightmost element: R, RG, G, GB, B, RB
    localparam logic [NUM_COLORS-1:0][2:0] COLOR_TABLE = {
        3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100
    };

    localparam int BRIGHT_STEP  = 16;
    localparam int BRIGHT_RESET = 8'h80;

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// One button: 2-flop synchronizer, consecutive-cycle debounce counter and a
// single-cycle pulse on the accepted 0->1 edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_accept;

    assign w_differs = r_sync != r_level;
    assign w_accept  = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign o_press   = r_press;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            r_press <= w_accept && r_sync;
            // Any cycle where the input agrees with the level restarts the count
            if (w_accept) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// Four-mode tri-colour LED sequencer (idle, manual, colour cycle, breathe)
// driven by debounced buttons, with PWM brightness and registered outputs.
module led_mode_sequencer
    import led_mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 25_000_000,
    parameter int PWM_BITS        = 8
) (
    input  logic                CLK100MHZ,
    input  logic                RST,
    input  logic [3:0]          BTN,
    input  logic [3:0]          SW,
    output logic [1:0]          RLED,
    output logic [1:0]          GLED,
    output logic [1:0]          BLED,
    output logic [3:0]          LED,
    output mode_t               o_dbg_state,
    output logic                o_dbg_paused,
    output logic [2:0]          o_dbg_color_idx,
    output logic [PWM_BITS-1:0] o_dbg_brightness,
    output logic [PWM_BITS-1:0] o_dbg_level
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] STEP_VAL = PWM_BITS'(BRIGHT_STEP);
    localparam logic [PWM_BITS-1:0] MAX_VAL  = '1;

    logic [3:0]          w_press;
    logic [3:0]          r_sw_meta, r_sw_sync;
    mode_t               r_state, w_state_next;
    logic                r_paused, r_dir_up;
    logic [PWM_BITS-1:0] r_brightness, r_pwm_cnt, r_level;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [2:0]          r_color_idx;
    logic [1:0]          r_rled, r_gled, r_bled;
    logic [3:0]          r_led;
    logic                w_mode_press, w_pause_press, w_up_press, w_dn_press;
    logic                w_run, w_tick, w_lit;
    logic [PWM_BITS:0]   w_bright_sum, w_level_sum;
    logic [PWM_BITS-1:0] w_bright_up, w_bright_dn;
    logic [PWM_BITS-1:0] w_level_cl, w_level_up, w_level_dn, w_duty;
    logic [2:0]          w_color;

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .i_clk   (CLK100MHZ),
            .i_rst   (RST),
            .i_btn   (BTN[gi]),
            .o_press (w_press[gi])
        );
    end

    // Same-cycle presses: mode beats pause beats brightness; up+down cancel
    assign w_mode_press  = w_press[0];
    assign w_pause_press = w_press[1] & ~w_press[0];
    assign w_up_press    = w_press[2] & ~w_press[3] & ~w_press[1] & ~w_press[0];
    assign w_dn_press    = w_press[3] & ~w_press[2] & ~w_press[1] & ~w_press[0];

    always_comb begin
        w_state_next = r_state;
        if (w_mode_press) begin
            case (r_state)
                MODE_IDLE:    w_state_next = MODE_MANUAL;
                MODE_MANUAL:  w_state_next = MODE_CYCLE;
                MODE_CYCLE:   w_state_next = MODE_BREATHE;
                default:      w_state_next = MODE_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) r_state <= MODE_IDLE;
        else     r_state <= w_state_next;
    end

    assign w_run  = ((r_state == MODE_CYCLE) || (r_state == MODE_BREATHE)) && !r_paused;
    assign w_tick = w_run && !w_mode_press && (r_step_cnt == STEP_W'(STEP_CYCLES - 1));

    assign w_bright_sum = {1'b0, r_brightness} + {1'b0, STEP_VAL};
    assign w_bright_up  = w_bright_sum[PWM_BITS] ? MAX_VAL : w_bright_sum[PWM_BITS-1:0];
    assign w_bright_dn  = (r_brightness < STEP_VAL) ? '0 : r_brightness - STEP_VAL;

    assign w_level_cl  = (r_level > r_brightness) ? r_brightness : r_level;
    assign w_level_sum = {1'b0, w_level_cl} + {1'b0, STEP_VAL};
    assign w_level_up  = (w_level_sum >= {1'b0, r_brightness}) ? r_brightness
                                                               : w_level_sum[PWM_BITS-1:0];
    assign w_level_dn  = (w_level_cl < STEP_VAL) ? '0 : w_level_cl - STEP_VAL;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            r_sw_meta    <= '0;
            r_sw_sync    <= '0;
            r_paused     <= 1'b0;
            r_brightness <= PWM_BITS'(BRIGHT_RESET);
            r_pwm_cnt    <= '0;
            r_step_cnt   <= '0;
            r_color_idx  <= '0;
            r_level      <= '0;
            r_dir_up     <= 1'b1;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;

            if (w_mode_press)
                r_paused <= 1'b0;
            else if (w_pause_press && (r_state == MODE_CYCLE || r_state == MODE_BREATHE))
                r_paused <= ~r_paused;

            if (w_up_press)      r_brightness <= w_bright_up;
            else if (w_dn_press) r_brightness <= w_bright_dn;

            if (w_mode_press || w_tick) r_step_cnt <= '0;
            else if (w_run)             r_step_cnt <= r_step_cnt + 1'b1;

            if (w_tick && r_state == MODE_CYCLE)
                r_color_idx <= (r_color_idx == 3'(NUM_COLORS - 1)) ? 3'd0 : r_color_idx + 3'd1;

            // Level always tracks a lowered brightness, even between ticks
            if (w_tick && r_state == MODE_BREATHE) begin
                if (r_dir_up) begin
                    r_level <= w_level_up;
                    if (w_level_up == r_brightness) r_dir_up <= 1'b0;
                end else begin
                    r_level <= w_level_dn;
                    if (w_level_dn == '0) r_dir_up <= 1'b1;
                end
            end else begin
                r_level <= w_level_cl;
            end
        end
    end

    always_comb begin
        w_color = 3'b000;
        w_duty  = '0;
        case (r_state)
            MODE_MANUAL: begin
                w_color = r_sw_sync[2:0];
                w_duty  = r_brightness;
            end
            MODE_CYCLE: begin
                w_color = COLOR_TABLE[r_color_idx];
                w_duty  = r_brightness;
            end
            MODE_BREATHE: begin
                w_color = 3'b111;
                w_duty  = r_level;
            end
            default: ;
        endcase
    end

    assign w_lit = r_pwm_cnt < w_duty;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            r_rled <= '0;
            r_gled <= '0;
            r_bled <= '0;
            r_led  <= '0;
        end else begin
            r_rled <= {w_color[2] & w_lit & r_sw_sync[3], w_color[2] & w_lit};
            r_gled <= {w_color[1] & w_lit & r_sw_sync[3], w_color[1] & w_lit};
            r_bled <= {w_color[0] & w_lit & r_sw_sync[3], w_color[0] & w_lit};
            r_led  <= 4'b0001 << r_state;
        end
    end

    assign RLED             = r_rled;
    assign GLED             = r_gled;
    assign BLED             = r_bled;
    assign LED              = r_led;
    assign o_dbg_state      = r_state;
    assign o_dbg_paused     = r_paused;
    assign o_dbg_color_idx  = r_color_idx;
    assign o_dbg_brightness = r_brightness;
    assign o_dbg_level      = r_level;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer: directed scenarios, a press
// vector table and a randomized press sequence against a behavioural model.
module tb_led_mode_sequencer;
    import led_mode_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [3:0] sw  = 4'b0;
    logic [1:0] rled, gled, bled;
    logic [3:0] led;
    mode_t      dbg_state;
    logic       dbg_paused;
    logic [2:0] dbg_color_idx;
    logic [7:0] dbg_brightness, dbg_level;

    int errors = 0;
    int checks = 0;

    led_mode_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .STEP_CYCLES     (16),
        .PWM_BITS        (8)
    ) dut (
        .CLK100MHZ        (clk),
        .RST              (rst),
        .BTN              (btn),
        .SW               (sw),
        .RLED             (rled),
        .GLED             (gled),
        .BLED             (bled),
        .LED              (led),
        .o_dbg_state      (dbg_state),
        .o_dbg_paused     (dbg_paused),
        .o_dbg_color_idx  (dbg_color_idx),
        .o_dbg_brightness (dbg_brightness),
        .o_dbg_level      (dbg_level)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] btn;
        int         exp_mode;
        int         exp_bright;
        int         exp_paused;
    } vec_t;

    vec_t       vecs[12];
    logic [2:0] color_ref[6];
    logic [7:0] exp_q[$];
    int         lit_cnt[6];
    logic [2:0] acc[6];
    logic [7:0] last, e, idx0, idx1;
    int         prev_st, prev_idx;
    int         m, mb, mp, act;
    logic [3:0] mask;
    logic       en;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver: hold long enough to debounce, then release and let it settle
    task automatic press(input logic [3:0] m_in);
        btn = m_in;
        tick(10);
        btn = 4'b0;
        tick(10);
    endtask

    task automatic measure();
        for (int j = 0; j < 6; j++) lit_cnt[j] = 0;
        repeat (256) begin
            @(negedge clk);
            lit_cnt[0] += int'(rled[0]);
            lit_cnt[1] += int'(rled[1]);
            lit_cnt[2] += int'(gled[0]);
            lit_cnt[3] += int'(gled[1]);
            lit_cnt[4] += int'(bled[0]);
            lit_cnt[5] += int'(bled[1]);
        end
    endtask

    initial begin
        color_ref = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        vecs[0]  = '{4'b0100, 1, 8'h90, 0};
        vecs[1]  = '{4'b0100, 1, 8'hA0, 0};
        vecs[2]  = '{4'b0100, 1, 8'hB0, 0};
        vecs[3]  = '{4'b0100, 1, 8'hC0, 0};
        vecs[4]  = '{4'b0100, 1, 8'hD0, 0};
        vecs[5]  = '{4'b0100, 1, 8'hE0, 0};
        vecs[6]  = '{4'b0100, 1, 8'hF0, 0};
        vecs[7]  = '{4'b0100, 1, 8'hFF, 0};
        vecs[8]  = '{4'b0100, 1, 8'hFF, 0};
        vecs[9]  = '{4'b1100, 1, 8'hFF, 0};
        vecs[10] = '{4'b0010, 1, 8'hFF, 0};
        vecs[11] = '{4'b1010, 1, 8'hFF, 0};

        // reset values
        #1 rst = 1'b1;
        tick(3);
        check("rst_led", led, 4'b0000);
        check("rst_rgb", {rled, gled, bled}, 6'b0);
        check("rst_state", dbg_state, MODE_IDLE);
        check("rst_bright", dbg_brightness, 8'h80);
        check("rst_idx_lvl_pause", {dbg_color_idx, dbg_level, dbg_paused}, 12'h0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("first_edge_led", led, 4'b0001);
        @(negedge clk);

        // bouncing mode button -> exactly one press
        btn = 4'b0001;
        tick(1);
        btn = 4'b0000;
        tick(1);
        btn = 4'b0001;
        tick(20);
        btn = 4'b0000;
        tick(10);
        check("bounce_state", dbg_state, MODE_MANUAL);
        check("bounce_led", led, 4'b0010);

        // manual colour, PWM duty 128/256
        sw = 4'b1101;
        tick(4);
        measure();
        check("man_r0", lit_cnt[0], 128);
        check("man_r1", lit_cnt[1], 128);
        check("man_g", lit_cnt[2] + lit_cnt[3], 0);
        check("man_b0", lit_cnt[4], 128);
        check("man_b1", lit_cnt[5], 128);
        sw = 4'b0101;
        tick(4);
        measure();
        check("man_led1_off", lit_cnt[1] + lit_cnt[3] + lit_cnt[5], 0);
        check("man_r0_sw3off", lit_cnt[0], 128);

        // brightness / priority vector table
        for (int i = 0; i < 12; i++) begin
            press(vecs[i].btn);
            check($sformatf("vec%0d_mode", i), dbg_state, vecs[i].exp_mode);
            check($sformatf("vec%0d_bright", i), dbg_brightness, vecs[i].exp_bright);
            check($sformatf("vec%0d_paused", i), dbg_paused, vecs[i].exp_paused);
        end

        // colour cycle: index order and the colour shown for each index
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'd0);
        for (int i = 0; i < 6; i++) acc[i] = 3'b000;
        last = 8'hFF;
        prev_st = 0;
        prev_idx = 0;
        btn = 4'b0001;
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            if (c == 10) btn = 4'b0000;
            if (prev_st == 2 && prev_idx < 6) acc[prev_idx] |= {rled[0], gled[0], bled[0]};
            if (dbg_state == MODE_CYCLE && 8'(dbg_color_idx) != last) begin
                last = 8'(dbg_color_idx);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("cycle_idx", last, e);
                end
            end
            prev_st = int'(dbg_state);
            prev_idx = int'(dbg_color_idx);
        end
        check("cycle_all_seen", exp_q.size(), 0);
        for (int i = 0; i < 6; i++) check($sformatf("cycle_color%0d", i), acc[i], color_ref[i]);

        // pause / resume in cycle
        press(4'b0010);
        check("pause_on", dbg_paused, 1);
        idx0 = 8'(dbg_color_idx);
        tick(64);
        check("pause_hold_idx", dbg_color_idx, idx0);
        press(4'b0010);
        check("pause_off", dbg_paused, 0);
        idx1 = 8'(dbg_color_idx);
        tick(20);
        check("resume_idx_moved", 8'(dbg_color_idx) != idx1, 1);
        press(4'b0010);
        check("pause_again", dbg_paused, 1);
        press(4'b0001);
        check("breathe_state", dbg_state, MODE_BREATHE);
        check("breathe_unpaused", dbg_paused, 0);
        check("breathe_led", led, 4'b1000);

        // breathe ramp, then clamp of a paused level to a lowered brightness
        exp_q = '{8'd16, 8'd32, 8'd48, 8'd64};
        last = dbg_level;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (dbg_level != last) begin
                last = dbg_level;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("breathe_level", last, e);
                end
            end
        end
        check("breathe_all_seen", exp_q.size(), 0);
        tick(48);
        press(4'b0010);
        check("breathe_paused", dbg_paused, 1);
        repeat (13) press(4'b1000);
        check("clamp_bright", dbg_brightness, 8'h2F);
        check("clamp_level", dbg_level, 8'h2F);
        measure();
        check("breathe_r0", lit_cnt[0], 47);
        check("breathe_g0", lit_cnt[2], 47);
        check("breathe_b0", lit_cnt[4], 47);
        check("breathe_led1_off", lit_cnt[1] + lit_cnt[3] + lit_cnt[5], 0);

        // asynchronous reset between clock edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", led, 4'b0000);
        check("async_rst_rgb", {rled, gled, bled}, 6'b0);
        check("async_rst_state", dbg_state, MODE_IDLE);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_led", led, 4'b0001);
        check("post_rst_bright", dbg_brightness, 8'h80);
        @(negedge clk);

        // randomized presses against a behavioural model
        m = 0;
        mb = 128;
        mp = 0;
        for (int i = 0; i < 40; i++) begin
            act = (i < 10) ? 3 : int'($urandom_range(0, 6));
            case (act)
                0:       mask = 4'b0001;
                1:       mask = 4'b0010;
                2:       mask = 4'b0100;
                3:       mask = 4'b1000;
                4:       mask = 4'b1100;
                5:       mask = 4'b0101;
                default: mask = 4'b0110;
            endcase
            press(mask);
            if (mask[0]) begin
                m = (m + 1) % 4;
                mp = 0;
            end else if (mask[1]) begin
                if (m >= 2) mp = 1 - mp;
            end else if (mask[2] && !mask[3]) begin
                mb = (mb + 16 > 255) ? 255 : mb + 16;
            end else if (mask[3] && !mask[2]) begin
                mb = (mb < 16) ? 0 : mb - 16;
            end
            check("rnd_state", dbg_state, m);
            check("rnd_bright", dbg_brightness, mb);
            check("rnd_paused", dbg_paused, mp);
            check("rnd_led", led, 32'd1 << m);
            if (m == 1) begin
                sw = 4'($urandom_range(0, 15));
                tick(4);
                measure();
                for (int j = 0; j < 6; j++) begin
                    en = sw[2 - j / 2] && ((j % 2 == 0) || sw[3]);
                    check($sformatf("rnd_pwm%0d", j), lit_cnt[j], en ? mb : 0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles before a button level is accepted.
REQ-002 The block SHALL have parameter STEP_CYCLES, default 25_000_000: cycles per sequence step or breathe step.
REQ-003 The block SHALL have parameter PWM_BITS, default 8: width of the PWM counter, brightness and duty.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port CLK100MHZ, input, 1 bit: the only clock.
REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port BTN, input, 4 bits, asynchronous: [0] mode, [1] pause, [2] brighter, [3] dimmer.
REQ-008 The block SHALL have port SW, input, 4 bits, asynchronous: [2:0] manual RGB, [3] enables tri-LED 1.
REQ-009 The block SHALL have ports RLED, GLED and BLED, output, 2 bits each: tri-color LED channels, where bit i belongs to LED i.
REQ-010 The block SHALL have port LED, output, 4 bits: one-hot mode indicator.

Function
REQ-011 BTN and SW SHALL each pass through a 2-flop synchronizer.
REQ-012 A button's debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-013 A press SHALL be a 1-cycle pulse on the debounced 0->1 edge; a release SHALL produce nothing.
REQ-014 The mode FSM SHALL have states IDLE, MANUAL, CYCLE and BREATHE; a BTN[0] press SHALL advance IDLE->MANUAL->CYCLE->BREATHE->IDLE.
REQ-015 A BTN[1] press SHALL toggle paused in CYCLE and BREATHE and be ignored in other states; paused SHALL clear on every mode change.
REQ-016 A BTN[2] press SHALL add 16 to brightness, saturating at 2^PWM_BITS-1; a BTN[3] press SHALL subtract 16, saturating at 0.
REQ-017 Presses arriving in the same cycle SHALL have priority BTN[0] > BTN[1] > BTN[2]/BTN[3], with a lower-priority press in that cycle dropped; BTN[2] and BTN[3] together SHALL leave brightness unchanged.
REQ-018 The PWM counter SHALL be free-running and wrapping; a channel SHALL be lit when it is enabled and pwm_cnt < duty, so duty 0 is always off and the maximum duty lights 255 of 256 cycles.
REQ-019 The step timer SHALL count 0..STEP_CYCLES-1, producing a 1-cycle step tick on wrap; it SHALL run only in CYCLE or BREATHE while not paused, and SHALL reset to 0 on a mode change.
REQ-020 IDLE: all LED channels SHALL be off.
REQ-021 MANUAL: color SHALL be SW[2:0] as {R,G,B} and duty SHALL be brightness.
REQ-022 CYCLE: color_idx SHALL advance 0..5 (R, RG, G, GB, B, RB) on each step tick, wrapping 5->0; duty SHALL be brightness.
REQ-023 BREATHE: color SHALL be RGB white.
REQ-024 BREATHE: level SHALL move by 16 per step tick, rising until it reaches brightness, then falling to 0, then rising again.
REQ-025 BREATHE: level SHALL clamp to brightness if brightness drops below it, and duty SHALL be level.
REQ-026 Tri-LED 0 SHALL always show the color; tri-LED 1 SHALL show the same color only when SW[3]=1 and SHALL otherwise be off.
REQ-027 LED SHALL be IDLE=0001, MANUAL=0010, CYCLE=0100, BREATHE=1000.
REQ-028 All outputs SHALL be registered, one cycle after the PWM compare.

Reset
REQ-029 While RST=1, every flop SHALL clear immediately, regardless of clock.
REQ-030 Reset values SHALL be: state IDLE, brightness 0x80, color_idx 0, level 0, direction up, paused 0, and all counters 0.
REQ-031 Debounced levels SHALL reset to 0, so a button held during reset SHALL produce a press once DEBOUNCE_CYCLES cycles have passed after release of reset.
REQ-032 Output reset values SHALL be RLED=GLED=BLED=0 and LED=0000.
REQ-033 LED SHALL become 0001 on the first clock edge after RST deasserts.

Structure
REQ-034 A shared package SHALL hold the mode enum, the color table (6 x 3 bits), the brightness step (16) and the reset brightness (0x80).
REQ-035 One sub-module, btn_debounce, SHALL contain a single button's synchronizer, debounce counter and press-pulse generator, and SHALL be instantiated four times.

Verification
REQ-036 Bench parameters SHALL be DEBOUNCE_CYCLES=4, STEP_CYCLES=16 and PWM_BITS=8.
REQ-037 Scenario 1: release reset, then BTN[0] bounces 1-0-1 inside 3 cycles and holds -> exactly one press; LED goes 0001->0010.
REQ-038 Scenario 2: MANUAL, SW=1_101, brightness 0x80 -> RLED=BLED=11 and GLED=00, lit for exactly 128 of 256 cycles; with SW[3]=0 -> bit 1 of each channel is 0.
REQ-039 Scenario 3: CYCLE, run 6x16 cycles -> color_idx goes 0,1,..,5,0 and tri-LED 0 follows the REQ-022 color order.
REQ-040 Scenario 4: CYCLE, then press BTN[1] -> color_idx holds for 64 cycles; press again -> it resumes; press BTN[0] -> BREATHE with paused=0.
REQ-041 Scenario 5: press BTN[2] nine times from 0x80 -> brightness is 0xFF; press BTN[2] and BTN[3] together -> brightness stays 0xFF.
REQ-042 Scenario 6: assert RST asynchronously mid-BREATHE -> all outputs are 0 before the next clock edge, and after release LED=0001 with brightness 0x80.
